// File: rtl/uart_mmio_responder_pkg.sv
// Shared definitions for the memory-mapped UART responder:
// register offsets, CON bit positions, FSM encodings and the baud divisor helper.
package uart_mmio_responder_pkg;

    localparam logic [31:0] OFF_TXD = 32'h0000_0000;
    localparam logic [31:0] OFF_RXD = 32'h0000_0004;
    localparam logic [31:0] OFF_CON = 32'h0000_0008;

    localparam int unsigned CON_TX_IE      = 0;
    localparam int unsigned CON_RX_IE      = 1;
    localparam int unsigned CON_TX_DONE    = 2;
    localparam int unsigned CON_RX_VALID   = 3;
    localparam int unsigned CON_TX_BUSY    = 4;
    localparam int unsigned CON_RX_OVERRUN = 5;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    function automatic int unsigned clks_per_bit(input int unsigned clk_freq,
                                                 input int unsigned baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_mmio_responder_baud_counter.sv
// Loadable bit-period down-counter; full_tc marks the last cycle of a bit,
// half_tc marks the last cycle of the first half-bit after a load.
module uart_baud_counter
    import uart_mmio_responder_pkg::*;
#(
    parameter int unsigned CPB = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    output logic half_tc,
    output logic full_tc
);

    localparam int unsigned W = (CPB > 2) ? $clog2(CPB) : 1;
    localparam logic [W-1:0] RELOAD = W'(CPB - 1);
    localparam logic [W-1:0] HALF   = W'(CPB - (CPB / 2));
    localparam logic [W-1:0] ZERO   = W'(0);
    localparam logic [W-1:0] ONE    = W'(1);

    logic [W-1:0] cnt_r;

    // Reload on demand, otherwise count down and rest at zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_r <= ZERO;
        end else if (load) begin
            cnt_r <= RELOAD;
        end else if (cnt_r != ZERO) begin
            cnt_r <= cnt_r - ONE;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign half_tc = (cnt_r == HALF);
    assign full_tc = (cnt_r == ZERO);

endmodule

// File: rtl/uart_mmio_responder.sv
// UART responder on the MEM-stage load/store port: TXD/RXD/CON registers,
// 8N1 serialiser/deserialiser and a registered interrupt request.
module uart_mmio_responder
    import uart_mmio_responder_pkg::*;
#(
    parameter int unsigned CLK_FREQ  = 50000000,
    parameter int unsigned BAUD      = 9600,
    parameter logic [31:0] BASE_ADDR = 32'h4000_0018
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_rd,
    input  logic        mem_wr,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    input  logic        uart_rx,
    output logic        uart_tx,
    output logic        irq
);

    localparam int unsigned CPB      = clks_per_bit(CLK_FREQ, BAUD);
    localparam logic [31:0] TXD_ADDR = BASE_ADDR + OFF_TXD;
    localparam logic [31:0] RXD_ADDR = BASE_ADDR + OFF_RXD;
    localparam logic [31:0] CON_ADDR = BASE_ADDR + OFF_CON;

    logic sel_txd_s, sel_rxd_s, sel_con_s;
    logic txd_wr_s, con_wr_s, rxd_rd_s, con_rd_s;
    logic unused_s;

    tx_state_t  tx_state_r, tx_state_s;
    logic [7:0] tx_shift_r, txd_hold_r;
    logic [2:0] tx_bit_r;
    logic       tx_line_r;
    logic       tx_busy_s, tx_go_s, tx_tick_s, tx_done_set_s, tx_load_s;
    logic       tx_full_s, tx_half_unused_s;

    rx_state_t  rx_state_r, rx_state_s;
    logic       rx_meta_r, rx_sync_r, rx_prev_r, rx_fall_s;
    logic [7:0] rx_shift_r, rx_data_r;
    logic [2:0] rx_bit_r;
    logic       rx_load_s, rx_sample_s, rx_store_s;
    logic       rx_half_s, rx_full_s;

    logic        tx_ie_r, rx_ie_r, tx_done_r, rx_valid_r, rx_overrun_r, irq_r;
    logic [31:0] con_s;

    // Word-address decode; the byte offset bits are don't-care.
    assign sel_txd_s = (addr[31:2] == TXD_ADDR[31:2]);
    assign sel_rxd_s = (addr[31:2] == RXD_ADDR[31:2]);
    assign sel_con_s = (addr[31:2] == CON_ADDR[31:2]);
    assign txd_wr_s  = mem_wr & sel_txd_s;
    assign con_wr_s  = mem_wr & sel_con_s;
    assign rxd_rd_s  = mem_rd & sel_rxd_s;
    assign con_rd_s  = mem_rd & sel_con_s;
    assign unused_s  = ^{addr[1:0], wdata[31:8]};

    uart_baud_counter #(.CPB(CPB)) u_tx_baud (
        .clk     (clk),
        .reset   (reset),
        .load    (tx_load_s),
        .half_tc (tx_half_unused_s),
        .full_tc (tx_full_s)
    );

    uart_baud_counter #(.CPB(CPB)) u_rx_baud (
        .clk     (clk),
        .reset   (reset),
        .load    (rx_load_s),
        .half_tc (rx_half_s),
        .full_tc (rx_full_s)
    );

    // TX state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_state_r <= TX_IDLE;
        end else begin
            tx_state_r <= tx_state_s;
        end
    end

    // TX next-state logic.
    always_comb begin
        tx_state_s = tx_state_r;
        case (tx_state_r)
            TX_IDLE:  if (txd_wr_s) tx_state_s = TX_START; else tx_state_s = TX_IDLE;
            TX_START: if (tx_full_s) tx_state_s = TX_DATA; else tx_state_s = TX_START;
            TX_DATA:  if (tx_full_s && (tx_bit_r == 3'd7)) tx_state_s = TX_STOP;
                      else tx_state_s = TX_DATA;
            TX_STOP:  if (tx_full_s) tx_state_s = TX_IDLE; else tx_state_s = TX_STOP;
            default:  tx_state_s = TX_IDLE;
        endcase
    end

    // TX output decode: start, bit-boundary tick and completion strobes.
    always_comb begin
        tx_busy_s     = 1'b0;
        tx_go_s       = 1'b0;
        tx_tick_s     = 1'b0;
        tx_done_set_s = 1'b0;
        case (tx_state_r)
            TX_IDLE:  tx_go_s = txd_wr_s;
            TX_START, TX_DATA: begin
                tx_busy_s = 1'b1;
                tx_tick_s = tx_full_s;
            end
            TX_STOP: begin
                tx_busy_s     = 1'b1;
                tx_tick_s     = tx_full_s;
                tx_done_set_s = tx_full_s;
            end
            default: tx_busy_s = 1'b0;
        endcase
    end

    assign tx_load_s = tx_go_s | tx_tick_s;

    // TX shifter and line register; the line is presented one bit ahead of the shift.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_shift_r <= 8'd0;
            tx_bit_r   <= 3'd0;
            tx_line_r  <= 1'b1;
        end else if (tx_go_s) begin
            tx_shift_r <= wdata[7:0];
            tx_bit_r   <= 3'd0;
            tx_line_r  <= 1'b0;
        end else if (tx_tick_s) begin
            case (tx_state_r)
                TX_START: tx_line_r <= tx_shift_r[0];
                TX_DATA: begin
                    if (tx_bit_r == 3'd7) begin
                        tx_line_r <= 1'b1;
                    end else begin
                        tx_line_r  <= tx_shift_r[1];
                        tx_shift_r <= {1'b0, tx_shift_r[7:1]};
                        tx_bit_r   <= tx_bit_r + 3'd1;
                    end
                end
                TX_STOP: tx_line_r <= 1'b1;
                default: tx_line_r <= 1'b1;
            endcase
        end else begin
            tx_line_r <= tx_line_r;
        end
    end

    // Two-flop synchroniser plus one delayed copy for falling-edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta_r <= 1'b1;
            rx_sync_r <= 1'b1;
            rx_prev_r <= 1'b1;
        end else begin
            rx_meta_r <= uart_rx;
            rx_sync_r <= rx_meta_r;
            rx_prev_r <= rx_sync_r;
        end
    end

    assign rx_fall_s = rx_prev_r & ~rx_sync_r;

    // RX state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_state_r <= RX_IDLE;
        end else begin
            rx_state_r <= rx_state_s;
        end
    end

    // RX next-state logic; a start bit that is high at mid-bit is a glitch.
    always_comb begin
        rx_state_s = rx_state_r;
        case (rx_state_r)
            RX_IDLE:  if (rx_fall_s) rx_state_s = RX_START; else rx_state_s = RX_IDLE;
            RX_START: if (!rx_half_s) rx_state_s = RX_START;
                      else if (rx_sync_r) rx_state_s = RX_IDLE;
                      else rx_state_s = RX_DATA;
            RX_DATA:  if (rx_full_s && (rx_bit_r == 3'd7)) rx_state_s = RX_STOP;
                      else rx_state_s = RX_DATA;
            RX_STOP:  if (rx_full_s) rx_state_s = RX_IDLE; else rx_state_s = RX_STOP;
            default:  rx_state_s = RX_IDLE;
        endcase
    end

    // RX output decode: counter reloads, mid-bit samples and good-stop store.
    always_comb begin
        rx_load_s   = 1'b0;
        rx_sample_s = 1'b0;
        rx_store_s  = 1'b0;
        case (rx_state_r)
            RX_IDLE:  rx_load_s = rx_fall_s;
            RX_START: rx_load_s = rx_half_s & ~rx_sync_r;
            RX_DATA: begin
                rx_load_s   = rx_full_s;
                rx_sample_s = rx_full_s;
            end
            RX_STOP:  rx_store_s = rx_full_s & rx_sync_r;
            default:  rx_load_s = 1'b0;
        endcase
    end

    // RX deserialiser, LSB arrives first so bits enter at the top.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_shift_r <= 8'd0;
            rx_bit_r   <= 3'd0;
        end else if (rx_sample_s) begin
            rx_shift_r <= {rx_sync_r, rx_shift_r[7:1]};
            rx_bit_r   <= rx_bit_r + 3'd1;
        end else if (rx_state_r == RX_IDLE) begin
            rx_bit_r   <= 3'd0;
        end else begin
            rx_bit_r   <= rx_bit_r;
        end
    end

    // Software-visible holding registers and enables.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            txd_hold_r <= 8'd0;
            rx_data_r  <= 8'd0;
            tx_ie_r    <= 1'b0;
            rx_ie_r    <= 1'b0;
        end else begin
            if (txd_wr_s) txd_hold_r <= wdata[7:0];
            if (rx_store_s) rx_data_r <= rx_shift_r;
            if (con_wr_s) begin
                tx_ie_r <= wdata[0];
                rx_ie_r <= wdata[1];
            end
        end
    end

    // Status flags: a set in the same cycle as a read-clear wins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_done_r    <= 1'b0;
            rx_valid_r   <= 1'b0;
            rx_overrun_r <= 1'b0;
        end else begin
            if (tx_done_set_s) tx_done_r <= 1'b1;
            else if (con_rd_s) tx_done_r <= 1'b0;
            if (rx_store_s) rx_valid_r <= 1'b1;
            else if (rxd_rd_s) rx_valid_r <= 1'b0;
            if (rx_store_s && rx_valid_r) rx_overrun_r <= 1'b1;
            else if (con_rd_s) rx_overrun_r <= 1'b0;
        end
    end

    // Interrupt request, one cycle behind the flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_r <= 1'b0;
        end else begin
            irq_r <= (tx_ie_r & tx_done_r) | (rx_ie_r & rx_valid_r);
        end
    end

    // CON register image.
    always_comb begin
        con_s                 = 32'd0;
        con_s[CON_TX_IE]      = tx_ie_r;
        con_s[CON_RX_IE]      = rx_ie_r;
        con_s[CON_TX_DONE]    = tx_done_r;
        con_s[CON_RX_VALID]   = rx_valid_r;
        con_s[CON_TX_BUSY]    = tx_busy_s;
        con_s[CON_RX_OVERRUN] = rx_overrun_r;
    end

    // Zero-latency load mux; the CPU captures this in the same cycle.
    always_comb begin
        rdata = 32'd0;
        if (mem_rd) begin
            if (sel_txd_s) rdata = {24'd0, txd_hold_r};
            else if (sel_rxd_s) rdata = {24'd0, rx_data_r};
            else if (sel_con_s) rdata = con_s;
            else rdata = 32'd0;
        end else begin
            rdata = 32'd0;
        end
    end

    assign uart_tx = tx_line_r;
    assign irq     = irq_r;

endmodule
